// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART transmit serializer between two requesters.
// Optional `UART_TX_SCHED_IRQ_EN adds a sticky completion interrupt (irq / irq_clr).
module uart_tx_scheduler #(
  parameter int DATA_W  = 32,
  parameter int DIV_W   = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DIV_W-1:0]  baud_div,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic [DATA_W-1:0] ser_buffer,
  output logic              ser_enable,
  input  logic              ser_complete,
  output logic              busy,
  output logic              done,
  output logic              done_id,
  output logic              timeout_err
`ifdef UART_TX_SCHED_IRQ_EN
  ,
  output logic              irq,
  input  logic              irq_clr
`endif
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [DIV_W-1:0] baud_cnt_r;
  logic [DIV_W-1:0] div_r;
  logic [TW-1:0]    tick_cnt_r;
  logic             last_grant_r;
  logic             cur_id_r;
  logic             seen_busy_r;
  logic             tick_s;
  logic             frame_end_s;
  logic             abort_s;
  logic             grant_valid_s;
  logic             grant_id_s;

  // Baud tick, frame-end / abort detection and round-robin grant selection
  always_comb begin
    tick_s        = (state_r == SEND) && (baud_cnt_r == div_r);
    frame_end_s   = (state_r == SEND) && seen_busy_r && ser_complete;
    abort_s       = tick_s && !frame_end_s && (tick_cnt_r == TW'(TIMEOUT - 1));
    grant_valid_s = req0_valid | req1_valid;
    grant_id_s    = (req0_valid && req1_valid) ? ~last_grant_r : req1_valid;
  end

  // Frame sequencer FSM with registered handshake, strobe and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r      <= IDLE;
      baud_cnt_r   <= '0;
      div_r        <= '0;
      tick_cnt_r   <= '0;
      last_grant_r <= 1'b1;
      cur_id_r     <= 1'b0;
      seen_busy_r  <= 1'b0;
      req0_ready   <= 1'b0;
      req1_ready   <= 1'b0;
      ser_buffer   <= '0;
      ser_enable   <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      done_id      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      req0_ready  <= 1'b0;
      req1_ready  <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
      ser_enable  <= 1'b0;
      case (state_r)
        IDLE: begin
          if (grant_valid_s) begin
            ser_buffer   <= grant_id_s ? req1_data : req0_data;
            cur_id_r     <= grant_id_s;
            last_grant_r <= grant_id_s;
            seen_busy_r  <= 1'b0;
            tick_cnt_r   <= '0;
            baud_cnt_r   <= '0;
            div_r        <= baud_div;
            req0_ready   <= ~grant_id_s;
            req1_ready   <= grant_id_s;
            busy         <= 1'b1;
            state_r      <= SEND;
          end else begin
            busy    <= 1'b0;
            state_r <= IDLE;
          end
        end
        SEND: begin
          if (!ser_complete) begin
            seen_busy_r <= 1'b1;
          end else begin
            seen_busy_r <= seen_busy_r;
          end
          // A new divisor is only picked up when the counter wraps
          if (tick_s) begin
            baud_cnt_r <= '0;
            div_r      <= baud_div;
            tick_cnt_r <= tick_cnt_r + TW'(1);
          end else begin
            baud_cnt_r <= baud_cnt_r + DIV_W'(1);
          end
          if (frame_end_s) begin
            done    <= 1'b1;
            done_id <= cur_id_r;
            state_r <= DONE;
          end else if (abort_s) begin
            timeout_err <= 1'b1;
            busy        <= 1'b0;
            state_r     <= IDLE;
          end else begin
            ser_enable <= tick_s;
            state_r    <= SEND;
          end
        end
        DONE: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          busy    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

`ifdef UART_TX_SCHED_IRQ_EN
  // Sticky completion interrupt; a clear in the same cycle as a set wins
  always_ff @(posedge clk) begin
    if (!rst) begin
      irq <= 1'b0;
    end else if (irq_clr) begin
      irq <= 1'b0;
    end else begin
      irq <= irq | done | timeout_err;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table for arbitration plus directed
// sequences for reset, single frame, timeout, mid-frame reset and the optional irq.
module tb_uart_tx_scheduler;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = 16'd0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = 32'd0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = 32'd0;
  logic        req1_ready;
  logic [31:0] ser_buffer;
  logic        ser_enable;
  logic        ser_complete = 1'b1;
  logic        busy;
  logic        done;
  logic        done_id;
  logic        timeout_err;
`ifdef UART_TX_SCHED_IRQ_EN
  logic        irq;
  logic        irq_clr = 1'b0;
  bit          clr_on_done = 1'b0;
`endif

  int checks = 0;
  int failures = 0;

  typedef struct { logic id; logic [31:0] data; } sb_t;
  sb_t sb[$];

  typedef struct { logic v0; logic v1; logic exp_id; } vec_t;
  vec_t vecs[10];

  uart_tx_scheduler #(.DATA_W(32), .DIV_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .ser_buffer(ser_buffer), .ser_enable(ser_enable), .ser_complete(ser_complete),
    .busy(busy), .done(done), .done_id(done_id), .timeout_err(timeout_err)
`ifdef UART_TX_SCHED_IRQ_EN
    , .irq(irq), .irq_clr(irq_clr)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic wait_grant(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      if (req0_ready || req1_ready) got = 1'b1;
    end
  endtask

  // Serializer model: goes busy after the grant, runs n_ticks strobes, then reports complete
  task automatic run_frame(input int n_ticks);
    bit  got;
    int  gap;
    int  nen;
    sb_t e;
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb[0];
    wait_grant(got);
    chk("grant_seen", {31'd0, got}, 32'd1);
    if (!got) return;
    chk("grant_id", {30'd0, req1_ready, req0_ready}, e.id ? 32'd2 : 32'd1);
    chk("busy_on_grant", {31'd0, busy}, 32'd1);
    chk("buffer_latch", ser_buffer, e.data);
    if (req0_ready) req0_valid = 1'b0;
    else req1_valid = 1'b0;
    ser_complete = 1'b0;
    gap = 0;
    nen = 0;
    while (nen < n_ticks && gap <= 2 * (int'(baud_div) + 1) + 4) begin
      @(negedge clk);
      gap++;
      chk("send_status", {28'd0, done, req0_ready, req1_ready, busy}, 32'd1);
      if (ser_enable) begin
        chk("enable_period", gap, int'(baud_div) + 1);
        gap = 0;
        nen++;
      end
    end
    chk("ticks_reached", nen, n_ticks);
    ser_complete = 1'b1;
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd1);
    chk("enable_off_in_done", {31'd0, ser_enable}, 32'd0);
    e = sb.pop_front();
    chk("done_id", {31'd0, done_id}, {31'd0, e.id});
    chk("buffer_held", ser_buffer, e.data);
`ifdef UART_TX_SCHED_IRQ_EN
    irq_clr = clr_on_done;
`endif
    @(negedge clk);
`ifdef UART_TX_SCHED_IRQ_EN
    irq_clr = 1'b0;
`endif
    chk("idle_after_done", {30'd0, busy, done}, 32'd0);
  endtask

  task automatic push(input logic id, input logic [31:0] data);
    sb_t e;
    e.id = id;
    e.data = data;
    sb.push_back(e);
  endtask

  initial begin
    bit got;
    bit bad;
    int cyc;
    int nen;
    bit seen_to;
    bit saw_done;

    vecs[0] = '{1'b1, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 1'b1};
    vecs[2] = '{1'b1, 1'b1, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b1};
    vecs[4] = '{1'b0, 1'b1, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b1, 1'b1};
    vecs[8] = '{1'b1, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b1, 1'b1};

    // Reset state, then idle with no requests
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {25'd0, req0_ready, req1_ready, ser_enable, busy, done, done_id, timeout_err}, 32'd0);
    chk("reset_buffer", ser_buffer, 32'd0);
    rst = 1'b1;
    bad = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (ser_enable || busy || req0_ready || req1_ready) bad = 1'b1;
    end
    chk("idle_quiet", {31'd0, bad}, 32'd0);

    // Single 35-tick frame from req0
    baud_div = 16'd3;
    req0_data = 32'hA5A5_0001;
    req0_valid = 1'b1;
    push(1'b0, 32'hA5A5_0001);
    run_frame(35);

    // Arbitration table starting from a fresh reset
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      baud_div = 16'(i % 3);
      req0_valid = vecs[i].v0;
      req1_valid = vecs[i].v1;
      req0_data = 32'hA5A5_0000 + 32'(i);
      req1_data = 32'h5A5A_0000 + 32'(i);
      push(vecs[i].exp_id, vecs[i].exp_id ? req1_data : req0_data);
      run_frame(2 + (i % 3));
    end

    // Timeout: serializer never reports busy
    baud_div = 16'd0;
    req0_valid = 1'b1;
    req1_valid = 1'b0;
    req0_data = 32'h0BAD_0001;
    wait_grant(got);
    chk("to_grant", {30'd0, req1_ready, req0_ready}, 32'd1);
    req0_valid = 1'b0;
    cyc = 0;
    nen = 0;
    seen_to = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 200 && !seen_to; i++) begin
      @(negedge clk);
      cyc++;
      if (done) saw_done = 1'b1;
      if (ser_enable) nen++;
      if (timeout_err) seen_to = 1'b1;
    end
    chk("to_seen", {31'd0, seen_to}, 32'd1);
    chk("to_latency", cyc, TO);
    chk("to_enables", nen, TO - 1);
    chk("to_no_done", {31'd0, saw_done}, 32'd0);
    chk("to_idle", {30'd0, busy, ser_enable}, 32'd0);
    @(negedge clk);
    chk("to_pulse_end", {31'd0, timeout_err}, 32'd0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 32'h0000_1110;
    req1_data = 32'h0000_2221;
    push(1'b1, 32'h0000_2221);
    run_frame(4);
    req0_valid = 1'b0;

    // Reset during SEND abandons the frame
    baud_div = 16'd1;
    req1_valid = 1'b1;
    req1_data = 32'hDEAD_0005;
    wait_grant(got);
    chk("mr_grant", {30'd0, req1_ready, req0_ready}, 32'd2);
    req1_valid = 1'b0;
    ser_complete = 1'b0;
    nen = 0;
    for (int i = 0; i < 100 && nen < 10; i++) begin
      @(negedge clk);
      if (ser_enable) nen++;
    end
    chk("mr_ticks", nen, 10);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_outputs", {25'd0, req0_ready, req1_ready, ser_enable, busy, done, done_id, timeout_err}, 32'd0);
    chk("mr_buffer", ser_buffer, 32'd0);
    ser_complete = 1'b1;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    req0_data = 32'hC0DE_0000;
    req1_data = 32'hC0DE_0001;
    push(1'b0, 32'hC0DE_0000);
    run_frame(3);
    req0_valid = 1'b0;
    req1_valid = 1'b0;

`ifdef UART_TX_SCHED_IRQ_EN
    // Sticky irq, explicit clear, and clear coinciding with done
    chk("irq_set", {31'd0, irq}, 32'd1);
    repeat (3) @(negedge clk);
    chk("irq_hold", {31'd0, irq}, 32'd1);
    irq_clr = 1'b1;
    @(negedge clk);
    irq_clr = 1'b0;
    chk("irq_cleared", {31'd0, irq}, 32'd0);
    clr_on_done = 1'b1;
    req0_valid = 1'b1;
    req0_data = 32'h1234_5678;
    push(1'b0, 32'h1234_5678);
    run_frame(2);
    clr_on_done = 1'b0;
    chk("irq_clr_wins", {31'd0, irq}, 32'd0);
`endif

    chk("sb_drained", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
